// File: rtl/x_uart_pkg.sv
// Shared constants, state encoding and timeout sizing for the UART receive deframer.
package x_uart_pkg;

   localparam logic [7:0] SOF = 8'hA5;

   typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} deframer_state_t;

   // A UART byte occupies 10 bit times (start + 8 data + stop).
   function automatic int tmo_cycles(input longint clk_hz, input longint baud, input longint bytes);
      return int'((bytes * 64'sd10 * clk_hz) / baud);
   endfunction

endpackage

// File: rtl/x_frame_buf.sv
// Single-frame payload store: one synchronous write port, one asynchronous read port.
// Write lands at the rising edge; read reflects the current contents combinationally.
module x_frame_buf #(
   parameter int p_depth = 16,
   parameter int p_aw    = 4
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [p_aw-1:0] i_waddr,
   input  logic [7:0]      i_wdata,
   input  logic [p_aw-1:0] i_raddr,
   output logic [7:0]      o_rdata
);

   logic [7:0] mem [p_depth];

   always_ff @(posedge i_clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/x_uart_rx_deframer.sv
// Hunts SOF/LEN/payload/CHK frames in the received byte stream and releases verified payloads.
// o_valid rises one cycle after the CHK byte; the input cannot stall, so bytes arriving during DRAIN are dropped.
module x_uart_rx_deframer
   import x_uart_pkg::*;
#(
   parameter int p_clk_hz        = 1000000,
   parameter int p_baud          = 115200,
   parameter int p_max_len       = 16,
   parameter int p_timeout_bytes = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_last,
   input  logic       i_accept,
   output logic       o_err_chk,
   output logic       o_err_len,
   output logic       o_err_tmo,
   output logic       o_err_ovf
);

   localparam int PW      = (p_max_len > 1) ? $clog2(p_max_len) : 1;
   localparam int TMO_CYC = tmo_cycles(p_clk_hz, p_baud, p_timeout_bytes);
   localparam int TW      = $clog2(TMO_CYC + 1);

   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
   localparam logic [7:0]    MAX_LEN  = 8'(p_max_len);

   deframer_state_t state, state_nxt;

   logic [7:0]    len;
   logic [7:0]    chk;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [TW-1:0] timer;
   logic [7:0]    rdata;

   logic wr_last, rd_last, counting, tmo_hit, buf_we;
   logic err_chk_nxt, err_len_nxt, err_tmo_nxt, err_ovf_nxt;

   assign wr_last  = (8'(wptr) == len - 8'd1);
   assign rd_last  = (8'(rptr) == len - 8'd1);
   assign counting = (state == LEN) || (state == PAYLOAD) || (state == CHK);
   assign tmo_hit  = counting && !i_valid && (timer == TMO_LAST);
   assign buf_we   = (state == PAYLOAD) && i_valid;

   x_frame_buf #(
      .p_depth (p_max_len),
      .p_aw    (PW)
   ) u_frame_buf (
      .i_clk   (i_clk),
      .i_we    (buf_we),
      .i_waddr (wptr),
      .i_wdata (i_data),
      .i_raddr (rptr),
      .o_rdata (rdata)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state     <= IDLE;
         o_err_chk <= 1'b0;
         o_err_len <= 1'b0;
         o_err_tmo <= 1'b0;
         o_err_ovf <= 1'b0;
      end else begin
         state     <= state_nxt;
         o_err_chk <= err_chk_nxt;
         o_err_len <= err_len_nxt;
         o_err_tmo <= err_tmo_nxt;
         o_err_ovf <= err_ovf_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      err_chk_nxt = 1'b0;
      err_len_nxt = 1'b0;
      err_tmo_nxt = 1'b0;
      err_ovf_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid && (i_data == SOF)) state_nxt = LEN;
         end
         LEN: begin
            if (i_valid) begin
               if ((i_data != 8'd0) && (i_data <= MAX_LEN)) begin
                  state_nxt = PAYLOAD;
               end else begin
                  err_len_nxt = 1'b1;
                  state_nxt   = IDLE;
               end
            end else if (tmo_hit) begin
               err_tmo_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         PAYLOAD: begin
            if (i_valid) begin
               if (wr_last) state_nxt = CHK;
            end else if (tmo_hit) begin
               err_tmo_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         CHK: begin
            if (i_valid) begin
               if (i_data == chk) begin
                  state_nxt = DRAIN;
               end else begin
                  err_chk_nxt = 1'b1;
                  state_nxt   = IDLE;
               end
            end else if (tmo_hit) begin
               err_tmo_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         DRAIN: begin
            err_ovf_nxt = i_valid;
            if (i_accept && rd_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_valid = (state == DRAIN);
      o_data  = o_valid ? rdata : 8'd0;
      o_last  = o_valid && rd_last;
   end

   // Timer restarts on every byte and only runs while a frame is being collected.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         len   <= 8'd0;
         chk   <= 8'd0;
         wptr  <= '0;
         rptr  <= '0;
         timer <= '0;
      end else begin
         if (i_valid || !counting || tmo_hit) timer <= '0;
         else                                 timer <= timer + 1'b1;

         case (state)
            LEN: begin
               if (i_valid) begin
                  len  <= i_data;
                  chk  <= i_data;
                  wptr <= '0;
               end
            end
            PAYLOAD: begin
               if (i_valid) begin
                  chk <= chk ^ i_data;
                  if (!wr_last) wptr <= wptr + 1'b1;
               end
            end
            CHK: begin
               if (i_valid) rptr <= '0;
            end
            DRAIN: begin
               if (i_accept && !rd_last) rptr <= rptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
